tx_frame_arbiter: RTL and testbench
===================================

# tx_frame_arbiter

Frame-granular arbiter that shares the single TX MAC AXI-Stream input among `NUM_PORTS` requesters. It sits directly upstream of the TX MAC. Once a port is granted, it owns the MAC for a whole frame, up to and including its `tlast` beat. The block also enforces a post-frame hold-off gap and recovers from a requester that stalls mid-frame.

## Interface
Parameters:
- `NUM_PORTS`, 4 — number of requesting AXIS slave ports (2..8).
- `DATA_WIDTH`, 32 — AXIS data width; keep width is `DATA_WIDTH/8`.
- `GAP_CYCLES`, 2 — idle cycles forced after each frame's `tlast` handshake (0..15).
- `TIMEOUT_CYCLES`, 256 — consecutive mid-frame `tvalid`-low cycles on the granted port that trigger an abort (≥2).

Ports:
- `tx_clk`  in  1  — single clock. One clock; reset is synchronous and active-high.
- `tx_rst`  in  1  — synchronous, active-high reset.
- `s_tdata`  in  `NUM_PORTS*DATA_WIDTH`  — per-port data; port p occupies slice p.
- `s_tkeep`  in  `NUM_PORTS*DATA_WIDTH/8`  — per-port byte enables.
- `s_tvalid`  in  `NUM_PORTS`  — per-port valid.
- `s_tlast`  in  `NUM_PORTS`  — per-port end of frame.
- `s_tready`  out  `NUM_PORTS`  — per-port ready.
- `m_tdata`  out  `DATA_WIDTH`  — data to the MAC.
- `m_tkeep`  out  `DATA_WIDTH/8`  — byte enables to the MAC.
- `m_tvalid`  out  1  — valid to the MAC.
- `m_tlast`  out  1  — end of frame to the MAC.
- `m_tready`  in  1  — ready from the MAC.
- `grant_id`  out  `$clog2(NUM_PORTS)`  — currently granted port.
- `grant_valid`  out  1  — a grant is active (GRANT or DROP state).
- `frame_done`  out  1  — one-cycle pulse on the `tlast` handshake of a forwarded frame.
- `timeout_err`  out  1  — one-cycle pulse when an abort fires.

## Operation
- States: IDLE, GRANT, ABORT, DROP, GAP.
- IDLE
  - Outputs quiet: all `s_tready` = 0, `m_tvalid` = 0.
  - If any `s_tvalid` is set, pick the winner: round-robin, first requesting port at or after `rr_ptr`, wrapping.
  - Register `grant_id`, set `grant_valid`, go to GRANT.
- GRANT
  - Combinational pass-through: `m_*` = `s_*[grant_id]`.
  - `s_tready[grant_id]` = `m_tready`; all other `s_tready` = 0.
  - Stall counter:
    - Cleared on every cycle with `s_tvalid[grant_id]` = 1.
    - Incremented otherwise, but only after the first beat of the frame has been accepted.
  - `tlast` handshake (`m_tvalid & m_tready & m_tlast`):
    - Pulse `frame_done`.
    - `rr_ptr` = `grant_id`+1 mod `NUM_PORTS`.
    - Go to GAP.
  - Stall counter reaches `TIMEOUT_CYCLES`: pulse `timeout_err`, go to ABORT.
- ABORT
  - Drive one beat: `m_tvalid` = 1, `m_tlast` = 1, `m_tkeep` = 0, `m_tdata` = 0.
  - All `s_tready` = 0.
  - Hold until `m_tready`, then go to DROP.
- DROP
  - `s_tready[grant_id]` = 1; `m_tvalid` = 0.
  - Discard beats until a handshake with `s_tlast[grant_id]`, then advance `rr_ptr` and go to GAP.
- GAP
  - All outputs quiet; `grant_valid` = 0.
  - Count `GAP_CYCLES`, then go to IDLE. With `GAP_CYCLES` = 0, go straight to IDLE in the same cycle.
- Widths:
  - Stall counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates.
  - Gap counter is 4 bits.

## Timing
- Reset values:
  - State = IDLE.
  - `rr_ptr` = 0, `grant_id` = 0, `grant_valid` = 0.
  - `s_tready` = 0, `m_tvalid` = 0, `m_tlast` = 0, `m_tkeep` = 0, `m_tdata` = 0.
  - `frame_done` = 0, `timeout_err` = 0.
- Reset asserted mid-frame: state returns to IDLE on the next edge. No `tlast` is synthesized.
- Arbitration latency: first granted beat can hand off 1 cycle after `s_tvalid` is seen in IDLE.
- Data path in GRANT has zero latency (combinational).
- Back-to-back frames from one port: `tlast` → GAP (`GAP_CYCLES`) → IDLE (1) → next beat. Minimum `GAP_CYCLES`+2 cycles between frames.
- A requester dropping `s_tvalid` in IDLE before the grant registers has no effect. The grant stays; its frame simply starts later and is subject to timeout.
- `m_tready` low never advances the stall counter unless `s_tvalid[grant_id]` is also low.

## Configuration
- `TX_ARB_STRICT_PRIO_EN`
  - Defined: IDLE always picks the lowest-numbered requesting port; `rr_ptr` is ignored and not updated.
  - Undefined: round-robin as described above.
  - Both builds keep frame-granular locking, gap and timeout behaviour.

## Structure
- Package `tx_arb_pkg`:
  - State enum (IDLE, GRANT, ABORT, DROP, GAP).
  - `ARB_MAX_PORTS` = 8.
  - Abort beat constants (keep = 0, data = 0).
- Sub-module `tx_arb_rr_pick`:
  - Combinational.
  - Inputs: request vector, `rr_ptr`.
  - Outputs: winner index, any-request flag.
  - The strict-priority build instantiates it with `rr_ptr` tied to 0.

## Test plan
- Port 2 sends one 16-word frame, `m_tready` = 1 → 16 beats on `m_*` with `grant_id` = 2; `frame_done` pulses once; `rr_ptr` = 3.
- Ports 0 and 1 request together, `rr_ptr` = 0 → port 0's frame is forwarded, then after 2 gap cycles port 1's frame. No interleaving.
- `TIMEOUT_CYCLES` = 8; port 1 stalls 8 cycles after its 3rd beat → `timeout_err` pulse, one beat with `tlast` = 1 and `tkeep` = 0; remaining beats up to `s_tlast` are consumed with `m_tvalid` = 0.
- `m_tready` toggles 1/0 every cycle during a 10-word frame → every word appears exactly once, in order; no timeout.
- `tx_rst` pulsed at beat 5 of a frame → next cycle `m_tvalid` = 0, `grant_valid` = 0, all `s_tready` = 0, `rr_ptr` = 0.
- `TX_ARB_STRICT_PRIO_EN` defined; ports 0 and 3 request continuously → port 0 wins every arbitration.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the TX frame arbiter: FSM encoding and abort-beat contents.
// No logic; latency and backpressure live in the modules that import this package.
// Abort beat is a zero-keep, zero-data tlast so the MAC closes the frame without extra bytes.
package tx_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ABORT,
        ST_DROP,
        ST_GAP
    } arb_state_t;

    localparam int ARB_MAX_PORTS = 8;

    localparam logic ABORT_KEEP_BIT = 1'b0;
    localparam logic ABORT_DATA_BIT = 1'b0;

endpackage

// File: rtl/tx_arb_rr_pick.sv
// Round-robin winner select: first requesting port at or after rr_ptr, wrapping.
// Purely combinational, zero latency; no backpressure (pure function of its inputs).
module tx_arb_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int IW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        rr_ptr,
    output logic [IW-1:0]        winner,
    output logic                 any_req
);

    int unsigned idx;

    // Scan offsets from the far end so the nearest requester to rr_ptr is written last.
    always_comb begin
        winner  = '0;
        any_req = |req;
        idx     = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_PORTS;
            if (req[idx]) begin
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-granular AXIS arbiter in front of the TX MAC, with post-frame gap and mid-frame stall abort.
// Latency: 1 cycle request-to-first-beat, data path combinational; TX_ARB_STRICT_PRIO_EN selects fixed priority.
// Backpressure: m_tready passes straight to the granted port; all other ports see s_tready low.
module tx_frame_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                            tx_clk,
    input  logic                            tx_rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    output logic [NUM_PORTS-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic [DATA_WIDTH/8-1:0]         m_tkeep,
    output logic                            m_tvalid,
    output logic                            m_tlast,
    input  logic                            m_tready,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
    output logic                            grant_valid,
    output logic                            frame_done,
    output logic                            timeout_err
);

    localparam int IW = $clog2(NUM_PORTS);
    localparam int KW = DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic            grant_valid_q, grant_valid_d;
    logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
    logic [3:0]      gap_cnt_q, gap_cnt_d;
    logic            started_q, started_d;

    logic [IW-1:0]   pick_ptr, pick_id, rr_next, rr_adv;
    logic            pick_any;
    logic            sel_vld, sel_last;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic [KW-1:0]   sel_keep;
    arb_state_t      after_frame;

    assign sel_vld     = s_tvalid[grant_id_q];
    assign sel_last    = s_tlast[grant_id_q];
    assign sel_dat     = s_tdata[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    assign sel_keep    = s_tkeep[grant_id_q*KW +: KW];
    assign rr_next     = (grant_id_q == IW'(NUM_PORTS - 1)) ? '0 : grant_id_q + 1'b1;
    assign after_frame = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

`ifdef TX_ARB_STRICT_PRIO_EN
    // Fixed priority: scan always starts at port 0 and the pointer stays frozen.
    assign pick_ptr = '0;
    assign rr_adv   = rr_ptr_q;
`else
    assign pick_ptr = rr_ptr_q;
    assign rr_adv   = rr_next;
`endif

    tx_arb_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IW        (IW)
    ) u_pick (
        .req     (s_tvalid),
        .rr_ptr  (pick_ptr),
        .winner  (pick_id),
        .any_req (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        stall_cnt_d = stall_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        started_d   = started_q;
        s_tready    = '0;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        m_tkeep     = '0;
        m_tdata     = '0;
        frame_done  = 1'b0;
        timeout_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_id_d  = pick_id;
                    stall_cnt_d = '0;
                    started_d   = 1'b0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                m_tvalid             = sel_vld;
                m_tlast              = sel_last;
                m_tkeep              = sel_keep;
                m_tdata              = sel_dat;
                s_tready[grant_id_q] = m_tready;
                // Stalls only count once the frame has started; the counter saturates.
                if (sel_vld) begin
                    stall_cnt_d = '0;
                end else if (started_q && stall_cnt_q != CW'(TIMEOUT_CYCLES)) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
                if (sel_vld && m_tready) begin
                    started_d = 1'b1;
                end
                if (sel_vld && m_tready && sel_last) begin
                    frame_done = 1'b1;
                    rr_ptr_d   = rr_adv;
                    gap_cnt_d  = '0;
                    state_d    = after_frame;
                end else if (!sel_vld && started_q && stall_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err = 1'b1;
                    state_d     = ST_ABORT;
                end
            end
            ST_ABORT: begin
                m_tvalid = 1'b1;
                m_tlast  = 1'b1;
                m_tkeep  = {KW{ABORT_KEEP_BIT}};
                m_tdata  = {DATA_WIDTH{ABORT_DATA_BIT}};
                if (m_tready) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                s_tready[grant_id_q] = 1'b1;
                if (sel_vld && sel_last) begin
                    rr_ptr_d  = rr_adv;
                    gap_cnt_d = '0;
                    state_d   = after_frame;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        grant_valid_d = (state_d == ST_GRANT) || (state_d == ST_DROP);
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            stall_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            started_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            stall_cnt_q   <= stall_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            started_q     <= started_d;
        end
    end

    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: per-port frame sources, MAC-side beat monitor, hand-built expectations.
module tb_tx_frame_arbiter;

    localparam int NP  = 4;
    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int GAP = 2;
    localparam int TMO = 8;
`ifdef TX_ARB_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic              tx_clk;
    logic              tx_rst;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*KW-1:0]  s_tkeep;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [1:0]        grant_id;
    logic              grant_valid;
    logic              frame_done;
    logic              timeout_err;

    tx_frame_arbiter #(
        .NUM_PORTS      (NP),
        .DATA_WIDTH     (DW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .tx_clk      (tx_clk),
        .tx_rst      (tx_rst),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    int n_tests;
    int n_fail;

    int len_a[NP];
    int k_a[NP];
    int frm_a[NP];
    int nfrm_a[NP];
    int stall_at_a[NP];
    int stall_rem_a[NP];
    logic [NP-1:0] act;
    bit tog_mode;
    int cyc;
    int req_cyc;
    int n_done;
    int n_tmo;

    logic [DW-1:0] mon_dat[$];
    logic [KW-1:0] mon_keep[$];
    logic          mon_last[$];
    logic [1:0]    mon_gid[$];
    int            mon_cyc[$];
    logic [DW-1:0] exp_dat[$];
    logic [KW-1:0] exp_keep[$];
    logic          exp_last[$];
    logic [1:0]    exp_gid[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int p, input int f, input int k);
        return {8'(p), 8'(f), 16'(k)};
    endfunction

    task automatic drive();
        logic v;
        for (int p = 0; p < NP; p++) begin
            v = act[p];
            if (act[p] && k_a[p] == stall_at_a[p] && stall_rem_a[p] > 0) begin
                v = 1'b0;
                stall_rem_a[p]--;
            end
            s_tvalid[p]            = v;
            s_tdata[p*DW +: DW]    = word(p, frm_a[p], k_a[p]);
            s_tkeep[p*KW +: KW]    = (k_a[p] == len_a[p] - 1) ? 4'h3 : 4'hF;
            s_tlast[p]             = (k_a[p] == len_a[p] - 1);
        end
        m_tready = tog_mode ? ~m_tready : 1'b1;
    endtask

    task automatic step();
        logic [NP-1:0] hs;
        @(negedge tx_clk);
        hs = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            mon_dat.push_back(m_tdata);
            mon_keep.push_back(m_tkeep);
            mon_last.push_back(m_tlast);
            mon_gid.push_back(grant_id);
            mon_cyc.push_back(cyc);
        end
        if (frame_done)  n_done++;
        if (timeout_err) n_tmo++;
        if (s_tvalid != '0 && req_cyc < 0) req_cyc = cyc;
        @(posedge tx_clk);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                k_a[p]++;
                if (k_a[p] == len_a[p]) begin
                    k_a[p] = 0;
                    frm_a[p]++;
                    if (frm_a[p] == nfrm_a[p]) act[p] = 1'b0;
                end
            end
        end
        drive();
    endtask

    task automatic start_src(input int p, input int len, input int nfrm, input int st_at, input int st_len);
        len_a[p]       = len;
        k_a[p]         = 0;
        frm_a[p]       = 0;
        nfrm_a[p]      = nfrm;
        stall_at_a[p]  = st_at;
        stall_rem_a[p] = st_len;
        act[p]         = 1'b1;
    endtask

    task automatic begin_test();
        mon_dat.delete(); mon_keep.delete(); mon_last.delete(); mon_gid.delete(); mon_cyc.delete();
        exp_dat.delete(); exp_keep.delete(); exp_last.delete(); exp_gid.delete();
        n_done  = 0;
        n_tmo   = 0;
        req_cyc = -1;
    endtask

    task automatic exp_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic [1:0] g);
        exp_dat.push_back(d);
        exp_keep.push_back(k);
        exp_last.push_back(l);
        exp_gid.push_back(g);
    endtask

    task automatic exp_frame(input int p, input int f, input int len);
        for (int k = 0; k < len; k++) begin
            exp_beat(word(p, f, k), (k == len - 1) ? 4'h3 : 4'hF, (k == len - 1), 2'(p));
        end
    endtask

    task automatic cmp_beats(input string tag);
        int n;
        check_eq({tag, "_nbeats"}, mon_dat.size(), exp_dat.size());
        n = (mon_dat.size() < exp_dat.size()) ? mon_dat.size() : exp_dat.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_dat[%0d]", tag, i),  mon_dat[i],  exp_dat[i]);
            check_eq($sformatf("%s_keep[%0d]", tag, i), mon_keep[i], exp_keep[i]);
            check_eq($sformatf("%s_last[%0d]", tag, i), mon_last[i], exp_last[i]);
            check_eq($sformatf("%s_gid[%0d]", tag, i),  mon_gid[i],  exp_gid[i]);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (act != '0 && n < budget) begin
            step();
            n++;
        end
        check_eq({tag, "_drained"}, act, '0);
        repeat (8) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        act      = '0;
        tog_mode = 1'b0;
        tx_rst   = 1'b1;
        m_tready = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        for (int p = 0; p < NP; p++) begin
            len_a[p] = 1; k_a[p] = 0; frm_a[p] = 0; nfrm_a[p] = 1;
            stall_at_a[p] = -1; stall_rem_a[p] = 0;
        end
        begin_test();

        // Reset state
        repeat (3) step();
        #1;
        check_eq("rst_m_tvalid", m_tvalid, 1'b0);
        check_eq("rst_m_tlast", m_tlast, 1'b0);
        check_eq("rst_m_tkeep", m_tkeep, '0);
        check_eq("rst_m_tdata", m_tdata, '0);
        check_eq("rst_s_tready", s_tready, '0);
        check_eq("rst_grant_valid", grant_valid, 1'b0);
        check_eq("rst_grant_id", grant_id, 2'd0);
        check_eq("rst_frame_done", frame_done, 1'b0);
        check_eq("rst_timeout_err", timeout_err, 1'b0);
        check_eq("rst_rr_ptr", dut.rr_ptr_q, 2'd0);
        tx_rst = 1'b0;
        step();

        // Single 16-word frame from port 2
        begin_test();
        start_src(2, 16, 1, -1, 0);
        drive();
        wait_drain("t1", 200);
        exp_frame(2, 0, 16);
        cmp_beats("t1");
        check_eq("t1_done", n_done, 1);
        check_eq("t1_tmo", n_tmo, 0);
        check_eq("t1_rr", dut.rr_ptr_q, STRICT ? 2'd0 : 2'd3);
        check_eq("t1_latency", mon_cyc[0] - req_cyc, 1);

        // m_tready toggling during a 10-word frame from port 3
        begin_test();
        tog_mode = 1'b1;
        start_src(3, 10, 1, -1, 0);
        drive();
        wait_drain("t4", 400);
        tog_mode = 1'b0;
        exp_frame(3, 0, 10);
        cmp_beats("t4");
        check_eq("t4_done", n_done, 1);
        check_eq("t4_tmo", n_tmo, 0);
        check_eq("t4_rr", dut.rr_ptr_q, 2'd0);

        // Ports 0 and 1 together with rr_ptr at 0
        begin_test();
        start_src(0, 4, 1, -1, 0);
        start_src(1, 3, 1, -1, 0);
        drive();
        wait_drain("t2", 200);
        exp_frame(0, 0, 4);
        exp_frame(1, 0, 3);
        cmp_beats("t2");
        check_eq("t2_done", n_done, 2);
        check_eq("t2_gap", mon_cyc[4] - mon_cyc[3], GAP + 2);
        check_eq("t2_rr", dut.rr_ptr_q, STRICT ? 2'd0 : 2'd2);

        // Port 1 stalls TMO cycles after its 3rd beat
        begin_test();
        start_src(1, 6, 1, 3, TMO);
        drive();
        wait_drain("t3", 200);
        for (int k = 0; k < 3; k++) exp_beat(word(1, 0, k), 4'hF, 1'b0, 2'd1);
        exp_beat('0, 4'h0, 1'b1, 2'd1);
        cmp_beats("t3");
        check_eq("t3_tmo", n_tmo, 1);
        check_eq("t3_done", n_done, 0);
        check_eq("t3_rr", dut.rr_ptr_q, STRICT ? 2'd0 : 2'd2);

        // Ports 0 and 3 contend with two 2-word frames each, rr_ptr at 2
        begin_test();
        start_src(0, 2, 2, -1, 0);
        start_src(3, 2, 2, -1, 0);
        drive();
        wait_drain("t6", 300);
`ifdef TX_ARB_STRICT_PRIO_EN
        exp_frame(0, 0, 2);
        exp_frame(0, 1, 2);
        exp_frame(3, 0, 2);
        exp_frame(3, 1, 2);
`else
        exp_frame(3, 0, 2);
        exp_frame(0, 0, 2);
        exp_frame(3, 1, 2);
        exp_frame(0, 1, 2);
`endif
        cmp_beats("t6");
        check_eq("t6_done", n_done, 4);
        check_eq("t6_rr", dut.rr_ptr_q, STRICT ? 2'd0 : 2'd1);

        // Reset pulsed mid-frame after 5 beats of a 12-word frame
        begin_test();
        start_src(0, 12, 1, -1, 0);
        drive();
        n = 0;
        while (mon_dat.size() < 5 && n < 100) begin
            step();
            n++;
        end
        check_eq("t5_reach", mon_dat.size(), 5);
        tx_rst = 1'b1;
        step();
        #1;
        check_eq("t5_m_tvalid", m_tvalid, 1'b0);
        check_eq("t5_grant_valid", grant_valid, 1'b0);
        check_eq("t5_s_tready", s_tready, '0);
        check_eq("t5_rr", dut.rr_ptr_q, 2'd0);
        exp_frame(0, 0, 12);
        while (exp_dat.size() > 6) begin
            void'(exp_dat.pop_back());
            void'(exp_keep.pop_back());
            void'(exp_last.pop_back());
            void'(exp_gid.pop_back());
        end
        cmp_beats("t5");
        act = '0;
        repeat (3) step();
        tx_rst = 1'b0;
        repeat (2) step();
        check_eq("t5_idle_tvalid", m_tvalid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
